// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
// Shared definitions for the pixel-stream blocks (frame_streamer on the
// transmit side, convolution_filter on the receive side).
//   - stream_state_e     : frame_streamer FSM states
//   - DEFAULT_IMG_WIDTH  : default pixels per row
//   - DEFAULT_IMG_HEIGHT : default rows per frame
//   - cnt_width()        : bit width of a counter spanning 0..n-1 (min 1)
// -----------------------------------------------------------------------------
package stream_pkg;

    localparam int DEFAULT_IMG_WIDTH  = 640;
    localparam int DEFAULT_IMG_HEIGHT = 480;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } stream_state_e;

    // A dimension of 1 still needs a 1-bit counter, which $clog2 would not give.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_fifo2.sv
// -----------------------------------------------------------------------------
// stream_fifo2
// Two-entry synchronous FIFO for valid/ready stream ports.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset, empties the FIFO
//   push_i       : write push_data_i this cycle
//   push_data_i  : data to write
//   pop_i        : remove the head entry this cycle
//   head_o       : oldest entry (meaningful while count_o != 0)
//   count_o      : number of stored entries, 0..2
// A push into a full FIFO is only taken when a pop frees a slot in the same
// cycle; a pop from an empty FIFO is ignored.
// -----------------------------------------------------------------------------
module stream_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push_s;
    logic         do_pop_s;

    assign do_pop_s  = pop_i && (count_q != 2'd0);
    assign do_push_s = push_i && ((count_q != 2'd2) || do_pop_s);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // The head slot is never the write slot while the FIFO holds data, so the
    // head stays stable until popped.
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/frame_streamer.sv
// -----------------------------------------------------------------------------
// frame_streamer
// Reads one grayscale frame from a synchronous-read memory (1-cycle latency)
// and emits it in raster order as a valid/ready pixel stream with start-of-
// frame and end-of-line markers. A 2-entry FIFO absorbs the read latency and
// downstream backpressure, giving one pixel per cycle while x_ready is high.
//
// Parameters: IMG_WIDTH, IMG_HEIGHT, W (pixel bits), ADDR_W (address bits).
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   start        : pulse, begins a frame when idle
//   busy         : high from accepted start until the frame completes
//   frame_done   : one-cycle pulse after the last pixel handshake
//   mem_rd_en    : memory read strobe
//   mem_addr     : read address, valid while mem_rd_en is high
//   mem_rd_data  : read data, valid one cycle after mem_rd_en
//   x_valid/x_ready/x_data : pixel stream
//   x_sof        : marks pixel 0 of the frame
//   x_eol        : marks the last pixel of each row
//
// Build option FRAME_STREAMER_LOOP_EN: when defined, the streamer wraps back
// to address 0 after the last read and streams frames back to back until
// reset; frame_done still pulses at each frame end and busy stays high.
// -----------------------------------------------------------------------------
module frame_streamer
    import stream_pkg::*;
#(
    parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT,
    parameter int W          = 8,
    parameter int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [W-1:0]      mem_rd_data,
    output logic              x_valid,
    input  logic              x_ready,
    output logic [W-1:0]      x_data,
    output logic              x_sof,
    output logic              x_eol
);

    localparam int COL_W = cnt_width(IMG_WIDTH);
    localparam int ROW_W = cnt_width(IMG_HEIGHT);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);

    stream_state_e     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              inflight_q;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;

    logic [1:0]        fifo_count_s;
    logic [W-1:0]      fifo_head_s;
    logic              valid_s;
    logic              pop_s;
    logic              rd_en_s;
    logic              last_pix_s;
    logic [2:0]        occupancy_s;

    assign valid_s    = (fifo_count_s != 2'd0);
    assign pop_s      = valid_s && x_ready;
    assign last_pix_s = (col_q == LAST_COL) && (row_q == LAST_ROW);

    // Slots that will still be claimed after this cycle's pop: buffered data
    // plus the read already in flight. A new read is only issued when it is
    // guaranteed a FIFO slot on arrival, so the FIFO never overflows.
    assign occupancy_s = {1'b0, fifo_count_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign rd_en_s     = (state_q == STREAM) && (occupancy_s < 3'd2);

    // Next-state logic for the read FSM, address, busy and frame_done.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = pop_s && last_pix_s;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = STREAM;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (rd_en_s && (addr_q == LAST_ADDR)) begin
`ifdef FRAME_STREAMER_LOOP_EN
                    state_d = STREAM;
                    addr_d  = '0;
`else
                    // Hold the last address rather than stepping past the
                    // frame; it is not presented again until the next start.
                    state_d = FLUSH;
                    addr_d  = addr_q;
`endif
                end else if (rd_en_s) begin
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    addr_d = addr_q;
                end
            end
            FLUSH: begin
                if (pop_s && last_pix_s) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = FLUSH;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Output-side raster position, advanced on every handshake and wrapped at
    // the frame end so the next frame (looped or restarted) begins at 0,0.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pop_s) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                if (row_q == LAST_ROW) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // State registers; reset also drops the in-flight marker so a read issued
    // just before reset is never written into the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            inflight_q <= rd_en_s;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

    // Read data lands in the FIFO on the edge after it is presented.
    stream_fifo2 #(
        .W (W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (inflight_q),
        .push_data_i (mem_rd_data),
        .pop_i       (pop_s),
        .head_o      (fifo_head_s),
        .count_o     (fifo_count_s)
    );

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign mem_rd_en  = rd_en_s;
    assign mem_addr   = addr_q;
    assign x_valid    = valid_s;
    assign x_data     = fifo_head_s;
    // Markers are qualified by x_valid so they read 0 whenever no pixel is
    // offered, including straight out of reset.
    assign x_sof      = valid_s && (col_q == '0) && (row_q == '0);
    assign x_eol      = valid_s && (col_q == LAST_COL);

endmodule

// File: tb/tb_frame_streamer.sv
// -----------------------------------------------------------------------------
// tb_frame_streamer
// Self-checking bench for frame_streamer at IMG_WIDTH=4, IMG_HEIGHT=3 with a
// memory whose data equals its address. A frame-level model (expected pixel
// index, busy, frame_done, outstanding read count) is compared against the DUT
// on every falling edge; directed scenarios add literal timing expectations.
// Build with FRAME_STREAMER_LOOP_EN defined to exercise looping mode.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_streamer;

    localparam int IW   = 4;
    localparam int IH   = 3;
    localparam int NPIX = IW * IH;
    localparam int W    = 8;
    localparam int AW   = 4;
`ifdef FRAME_STREAMER_LOOP_EN
    localparam int NF   = 3;
`else
    localparam int NF   = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          frame_done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_rd_data;
    logic          x_valid;
    logic          x_ready;
    logic [W-1:0]  x_data;
    logic          x_sof;
    logic          x_eol;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    frame_streamer #(
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .W          (W),
        .ADDR_W     (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .frame_done  (frame_done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .x_data      (x_data),
        .x_sof       (x_sof),
        .x_eol       (x_eol)
    );

    // Frame memory: data = address, one cycle after the read; noise otherwise.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 8'(mem_addr);
        else           mem_rd_data <= 8'($urandom);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model + per-cycle compare -------
    int         exp_pix     = 0;
    int         rd_issued   = 0;
    int         outstanding = 0;
    int         done_count  = 0;
    bit         exp_busy    = 1'b0;
    bit         exp_done    = 1'b0;
    bit         armed       = 1'b0;
    bit         prev_rst    = 1'b0;
    bit         prev_stall  = 1'b0;
    bit         hs_s;
    logic [W-1:0] prev_data;
    logic       prev_sof;
    logic       prev_eol;

    always @(negedge clk) begin
        hs_s = x_valid && x_ready;
        if (armed) begin
            if (prev_rst) begin
                chk("rst_busy",       int'(busy),       0);
                chk("rst_frame_done", int'(frame_done), 0);
                chk("rst_mem_rd_en",  int'(mem_rd_en),  0);
                chk("rst_mem_addr",   int'(mem_addr),   0);
                chk("rst_x_valid",    int'(x_valid),    0);
                chk("rst_x_data",     int'(x_data),     0);
                chk("rst_x_sof",      int'(x_sof),      0);
                chk("rst_x_eol",      int'(x_eol),      0);
            end else begin
                chk("busy",       int'(busy),       int'(exp_busy));
                chk("frame_done", int'(frame_done), int'(exp_done));
                if (frame_done) done_count++;
                if (mem_rd_en) begin
                    chk("rd_while_active", int'(exp_busy), 1);
                    chk("mem_addr", int'(mem_addr), rd_issued);
`ifndef FRAME_STREAMER_LOOP_EN
                    chk("reads_per_frame", int'(rd_issued < NPIX), 1);
`endif
                end
                chk("occupancy_bound", int'(outstanding + int'(mem_rd_en) - int'(hs_s) <= 2), 1);
                if (x_valid) chk("valid_has_data", int'(outstanding > 0), 1);
                if (prev_stall) begin
                    chk("hold_x_valid", int'(x_valid), 1);
                    chk("hold_x_data",  int'(x_data),  int'(prev_data));
                    chk("hold_x_sof",   int'(x_sof),   int'(prev_sof));
                    chk("hold_x_eol",   int'(x_eol),   int'(prev_eol));
                end
                if (hs_s) begin
                    chk("x_data", int'(x_data), exp_pix % 256);
                    chk("x_sof",  int'(x_sof),  int'(exp_pix == 0));
                    chk("x_eol",  int'(x_eol),  int'((exp_pix % IW) == IW - 1));
                end
            end
        end
        // advance the model to what must hold after the coming edge
        if (rst) begin
            exp_pix     = 0;
            rd_issued   = 0;
            outstanding = 0;
            exp_busy    = 1'b0;
            exp_done    = 1'b0;
            armed       = 1'b1;
        end else if (armed) begin
            exp_done = hs_s && (exp_pix == NPIX - 1);
            if (!exp_busy && start) begin
                exp_busy  = 1'b1;
                rd_issued = 0;
            end
            if (mem_rd_en) begin
                outstanding++;
`ifdef FRAME_STREAMER_LOOP_EN
                rd_issued = (rd_issued + 1) % NPIX;
`else
                rd_issued++;
`endif
            end
            if (hs_s) begin
                outstanding--;
                if (exp_pix == NPIX - 1) begin
                    exp_pix = 0;
`ifndef FRAME_STREAMER_LOOP_EN
                    exp_busy = 1'b0;
`endif
                end else begin
                    exp_pix++;
                end
            end
        end
        prev_stall = x_valid && !x_ready && !rst;
        prev_data  = x_data;
        prev_sof   = x_sof;
        prev_eol   = x_eol;
        prev_rst   = rst;
    end

    // ---------------- stimulus ----------------
    int   pat [6] = '{1, 0, 0, 1, 0, 1};
    logic v_log  [40];
    logic [W-1:0] d_log [40];
    logic fd_log [40];
    bit   seen;

    // mode 0: ready=1, 1: fixed backpressure pattern, 2: random ready
    task automatic run_frame(input int mode, input int budget, input bit pulse,
                             input bit poke5, input bit chain);
        bit done = 1'b0;
        int n = 0;
        start = pulse;
        while (!done && n < budget) begin
            case (mode)
                0:       x_ready = 1'b1;
                1:       x_ready = (pat[n % 6] != 0);
                default: x_ready = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            if (poke5 && x_valid && x_data == 8'd5) start = 1'b1;
            if (frame_done) begin
                done = 1'b1;
                if (chain) start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        chk("frame_completes", int'(done), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; x_ready = 1'b0;
        // reset held 3 cycles with arbitrary inputs
        for (int i = 0; i < 3; i++) begin
            start   = 1'($urandom);
            x_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x_ready = 1'($urandom);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("idle_x_valid", int'(x_valid), 0);
        chk("idle_busy",    int'(busy),    0);
        @(posedge clk); #1;

        // full throughput: start sampled at E0
        x_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            v_log[c]  = x_valid;
            d_log[c]  = x_data;
            fd_log[c] = frame_done;
        end
        chk("lat_after_e0", int'(v_log[0]), 0);
        chk("lat_after_e1", int'(v_log[1]), 0);
        for (int i = 0; i < NF * NPIX; i++) begin
            chk("thru_valid", int'(v_log[2 + i]), 1);
            chk("thru_data",  int'(d_log[2 + i]), i % NPIX);
        end
        for (int f = 0; f < NF; f++) begin
            chk("thru_no_early_done", int'(fd_log[13 + NPIX * f]), 0);
            chk("thru_done",          int'(fd_log[14 + NPIX * f]), 1);
        end
`ifdef FRAME_STREAMER_LOOP_EN
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("loop_done_count", done_count, 3);
`else
        chk("thru_idle_after", int'(v_log[14]), 0);
        chk("thru_busy_after", int'(busy), 0);

        // backpressure pattern, then random backpressure
        run_frame(1, 400, 1'b1, 1'b0, 1'b0);
        run_frame(2, 400, 1'b1, 1'b0, 1'b0);
        run_frame(2, 400, 1'b1, 1'b0, 1'b0);

        // start at pixel 5 ignored; start in the frame_done cycle accepted
        run_frame(0, 200, 1'b1, 1'b1, 1'b1);
        run_frame(2, 400, 1'b0, 1'b0, 1'b0);

        // reset right after the handshake of pixel 5
        seen = 1'b0; start = 1'b1; x_ready = 1'b1;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (x_valid && x_ready && x_data == 8'd5) seen = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("saw_pixel5", int'(seen), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_x_valid", int'(x_valid), 0);
        chk("rst_mid_busy",    int'(busy),    0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            x_ready = 1'($urandom);
        end
        run_frame(0, 200, 1'b1, 1'b0, 1'b0);

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("frame_count", done_count, 7);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
